// File: rtl/frame_align_monitor.sv
// frame_align_monitor: lock/resync supervisor for one VFAT frame aligner, with S-bit gating and status counters.
// Optional S-bit activity counter enabled by defining FRAME_ALIGN_MONITOR_SBIT_RATE_EN.
module frame_align_monitor #(
    parameter int MXSBITS      = 64,
    parameter int LOCK_CYCLES  = 256,
    parameter int ERR_THRESH   = 4,
    parameter int WINDOW       = 4096,
    parameter int RESET_CYCLES = 16,
    parameter int CNT_BITS     = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                cnt_reset,
    input  logic                alignment_error,
    input  logic [MXSBITS-1:0]  sbits_i,
    output logic                aligner_reset,
    output logic                locked,
    output logic [MXSBITS-1:0]  sbits_o,
    output logic [CNT_BITS-1:0] err_cnt,
    output logic [CNT_BITS-1:0] resync_cnt,
    output logic [CNT_BITS-1:0] sbit_rate_cnt
);
    localparam int CW = $clog2(LOCK_CYCLES > RESET_CYCLES ? LOCK_CYCLES : RESET_CYCLES) + 1;
    localparam int WW = $clog2(WINDOW) + 1;
    localparam int EW = $clog2(ERR_THRESH + 1) + 1;

    typedef enum logic [1:0] {IDLE, WAIT_LOCK, LOCKED, RESYNC} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_ctr;
    logic [WW-1:0] r_win;
    logic [EW-1:0] r_win_err, w_win_err_nxt;
    logic          w_wrap, w_err_inc, w_resync_inc;

    always_comb begin
        w_wrap        = r_win == WW'(WINDOW - 1);
        // an error on the wrap cycle is the first error of the new window
        w_win_err_nxt = w_wrap ? EW'(alignment_error) : r_win_err + EW'(alignment_error);
        w_next        = r_state;
        case (r_state)
            IDLE:      w_next = WAIT_LOCK;
            WAIT_LOCK: if (!alignment_error && r_ctr == CW'(LOCK_CYCLES - 1)) w_next = LOCKED;
            LOCKED:    if (alignment_error && w_win_err_nxt >= EW'(ERR_THRESH)) w_next = RESYNC;
            RESYNC:    if (r_ctr == CW'(RESET_CYCLES - 1)) w_next = WAIT_LOCK;
            default:   w_next = IDLE;
        endcase
        if (!enable) w_next = IDLE;
        w_err_inc    = r_state == LOCKED && alignment_error;
        w_resync_inc = r_state == LOCKED && w_next == RESYNC;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ctr         <= '0;
            r_win         <= '0;
            r_win_err     <= '0;
            aligner_reset <= 1'b1;
            locked        <= 1'b0;
            sbits_o       <= '0;
            err_cnt       <= '0;
            resync_cnt    <= '0;
        end else begin
            r_state       <= w_next;
            r_ctr         <= (w_next != r_state || (r_state == WAIT_LOCK && alignment_error)) ? '0 : r_ctr + CW'(1);
            r_win         <= (r_state != LOCKED || w_wrap) ? '0 : r_win + WW'(1);
            r_win_err     <= r_state == LOCKED ? w_win_err_nxt : '0;
            aligner_reset <= r_state == IDLE || r_state == RESYNC;
            locked        <= r_state == LOCKED;
            sbits_o       <= r_state == LOCKED ? sbits_i : '0;
            err_cnt       <= cnt_reset ? '0 : err_cnt + CNT_BITS'(w_err_inc && ~&err_cnt);
            resync_cnt    <= cnt_reset ? '0 : resync_cnt + CNT_BITS'(w_resync_inc && ~&resync_cnt);
        end
    end

`ifdef FRAME_ALIGN_MONITOR_SBIT_RATE_EN
    always_ff @(posedge clock) begin
        sbit_rate_cnt <= (reset || cnt_reset) ? '0 :
                         sbit_rate_cnt + CNT_BITS'(r_state == LOCKED && |sbits_i && ~&sbit_rate_cnt);
    end
`else
    assign sbit_rate_cnt = '0;
`endif
endmodule

// File: tb/tb_frame_align_monitor.sv
// tb_frame_align_monitor: random stimulus against a window/run-length reference model, scoreboard-checked every cycle.
module tb_frame_align_monitor;
    localparam int MX = 8, LC = 8, ET = 3, W = 32, RC = 4, CB = 4;
    localparam int MAXC = (1 << CB) - 1;

    logic          clock = 1'b0;
    logic          reset, enable, cnt_reset, alignment_error;
    logic [MX-1:0] sbits_i, sbits_o;
    logic          aligner_reset, locked;
    logic [CB-1:0] err_cnt, resync_cnt, sbit_rate_cnt;

    frame_align_monitor #(
        .MXSBITS(MX), .LOCK_CYCLES(LC), .ERR_THRESH(ET),
        .WINDOW(W), .RESET_CYCLES(RC), .CNT_BITS(CB)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .cnt_reset(cnt_reset),
        .alignment_error(alignment_error), .sbits_i(sbits_i),
        .aligner_reset(aligner_reset), .locked(locked), .sbits_o(sbits_o),
        .err_cnt(err_cnt), .resync_cnt(resync_cnt), .sbit_rate_cnt(sbit_rate_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          ar, lk;
        logic [MX-1:0] sb;
        int            ec, rc, sr;
    } exp_t;

    typedef enum {M_IDLE, M_WAIT, M_LOCK, M_RSYNC} mode_t;

    exp_t  q[$];
    int    n_checks = 0, n_fail = 0;
    mode_t mode = M_IDLE;
    int    run = 0, lk = 0, rs = 0, ec = 0, rc = 0, sr = 0;
    int    errs[$];

    function automatic int sat(input int v);
        return v > MAXC ? MAXC : v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Model: lock after LC consecutive clean cycles; errors grouped by window id (k+1)/W.
    task automatic step(input bit r, input bit e, input bit c, input bit a, input logic [MX-1:0] s);
        exp_t  x;
        mode_t nm;
        int    id, n;
        reset = r; enable = e; cnt_reset = c; alignment_error = a; sbits_i = s;
        x.ar = r || mode == M_IDLE || mode == M_RSYNC;
        x.lk = !r && mode == M_LOCK;
        x.sb = (!r && mode == M_LOCK) ? s : '0;
        if (r) begin
            mode = M_IDLE; ec = 0; rc = 0; sr = 0;
        end else begin
            nm = mode;
            if (mode == M_LOCK) begin
                if (a) ec = sat(ec + 1);
`ifdef FRAME_ALIGN_MONITOR_SBIT_RATE_EN
                if (|s) sr = sat(sr + 1);
`endif
            end
            case (mode)
                M_IDLE: begin nm = M_WAIT; run = 0; end
                M_WAIT: begin
                    run = a ? 0 : run + 1;
                    if (run == LC) begin nm = M_LOCK; lk = 0; errs.delete(); end
                end
                M_LOCK: begin
                    if (a) begin
                        id = (lk + 1) / W;
                        errs.push_back(id);
                        n = 0;
                        foreach (errs[i]) if (errs[i] == id) n++;
                        if (n >= ET) begin nm = M_RSYNC; rs = 0; end
                    end
                    lk++;
                end
                M_RSYNC: begin
                    rs++;
                    if (rs == RC) begin nm = M_WAIT; run = 0; end
                end
            endcase
            if (!e) nm = M_IDLE;
            else if (mode == M_LOCK && nm == M_RSYNC) rc = sat(rc + 1);
            if (c) begin ec = 0; rc = 0; sr = 0; end
            mode = nm;
        end
        x.ec = ec; x.rc = rc; x.sr = sr;
        q.push_back(x);
        @(posedge clock);
        #2;
    endtask

    exp_t m;
    always @(posedge clock) begin
        #1;
        if (q.size() > 0) begin
            m = q.pop_front();
            chk("aligner_reset", int'(aligner_reset), int'(m.ar));
            chk("locked", int'(locked), int'(m.lk));
            chk("sbits_o", int'(sbits_o), int'(m.sb));
            chk("err_cnt", int'(err_cnt), m.ec);
            chk("resync_cnt", int'(resync_cnt), m.rc);
            chk("sbit_rate_cnt", int'(sbit_rate_cnt), m.sr);
        end
    end

    initial begin
        int rate[4] = '{4, 20, 60, 8};
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 1500; i++) begin
                step($urandom_range(0, 699) == 0,
                     $urandom_range(0, 299) != 0,
                     $urandom_range(0, 249) == 0,
                     $urandom_range(0, rate[p] - 1) == 0,
                     $urandom_range(0, 3) == 0 ? '0 : MX'($urandom));
            end
        end
        #10;
        chk("scoreboard_drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_align_monitor.md
Name: frame_align_monitor

Overview:
Per-VFAT supervisor placed directly downstream of the frame aligner. It consumes the aligner's alignment_error and sbits outputs and runs a lock/resync state machine. When alignment errors persist it pulses the aligner's reset to force re-alignment. It also gates S-bits to the cluster finder while unlocked and keeps saturating error and resync counters for slow control.

Parameters:
- MXSBITS, 64, S-bit width per VFAT; 128 when the aligner is built DDR.
- LOCK_CYCLES, 256, consecutive error-free cycles required to declare lock; must be ≥ 2.
- ERR_THRESH, 4, number of alignment errors within one window that triggers a resync; must be ≥ 1.
- WINDOW, 4096, error-window length in clock cycles.
- RESET_CYCLES, 16, length of the aligner_reset pulse in cycles; must be ≥ 1.
- CNT_BITS, 16, width of the status counters.

Ports:
- clock, in, 1, 40 MHz LHC clock.
- reset, in, 1, synchronous, active-high.
- enable, in, 1, 0 forces IDLE (VFAT masked).
- cnt_reset, in, 1, synchronous clear of err_cnt and resync_cnt.
- alignment_error, in, 1, from frame aligner.
- sbits_i, in, MXSBITS, from frame aligner.
- aligner_reset, out, 1, drives the aligner's reset_i.
- locked, out, 1, high in LOCKED.
- sbits_o, out, MXSBITS, gated S-bits.
- err_cnt, out, CNT_BITS, saturating count of alignment errors seen in LOCKED.
- resync_cnt, out, CNT_BITS, saturating count of resyncs.
- sbit_rate_cnt, out, CNT_BITS, optional S-bit activity count.

Behaviour:
- Reset (synchronous, active-high; clock is clock): state=IDLE, aligner_reset=1, locked=0, sbits_o=0, all counters 0.
- States:
  - IDLE: aligner_reset=1. Goes to WAIT_LOCK on the first cycle with enable=1.
  - WAIT_LOCK: aligner_reset=0. lock_ctr increments each cycle with alignment_error=0 and clears to 0 on error. When lock_ctr reaches LOCK_CYCLES-1 with no error, the next state is LOCKED. No timeout: the block waits indefinitely.
  - LOCKED: locked=1. The window counter counts 0..WINDOW-1 and wraps. Each alignment_error increments win_err and err_cnt. When win_err reaches ERR_THRESH, the next state is RESYNC.
  - RESYNC: aligner_reset=1 for exactly RESET_CYCLES cycles. resync_cnt increments once on entry. Next state is WAIT_LOCK with lock_ctr=0.
- enable=0 in any state goes to IDLE on the next cycle. This does not count as a resync.
- Window wrap coincident with an error: win_err=1, not 0. Window wrap without an error: win_err=0.
- Entry into LOCKED clears the window counter and win_err.
- ERR_THRESH=1: the first error in LOCKED triggers RESYNC.
- locked and aligner_reset are registered state decodes, valid 1 cycle after the state change.
- sbits_o is registered with 1-cycle latency: sbits_o = (state==LOCKED) ? sbits_i : 0. The sbits_i accepted on the cycle the error threshold is hit is still forwarded; zeros start the following cycle.
- Counters saturate at all-ones.
- cnt_reset has priority over a simultaneous increment; the result is 0.
- reset asserted during RESYNC aborts the pulse count and returns to IDLE. aligner_reset stays 1 throughout.

Optional Feature:
FRAME_ALIGN_MONITOR_SBIT_RATE_EN.
- Defined: sbit_rate_cnt increments (saturating) on every cycle in LOCKED with |sbits_i=1. It is cleared by reset and cnt_reset.
- Undefined: sbit_rate_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Reset, then enable=1 with alignment_error=0 throughout (LOCK_CYCLES=256) → locked rises 257 cycles after WAIT_LOCK entry; aligner_reset=0 from WAIT_LOCK entry; sbits_o=0 until locked, then equals sbits_i one cycle later.
- In WAIT_LOCK, inject an error at lock_ctr=200 → lock_ctr restarts; lock is declared 256 error-free cycles after the error.
- In LOCKED, 4 errors within 4096 cycles → RESYNC; aligner_reset high for exactly 16 cycles; resync_cnt=1, err_cnt=4; relock after a further 256 clean cycles.
- In LOCKED, 3 errors, window wraps, then 3 more errors → no resync; err_cnt=6; an error on the wrap cycle leaves win_err=1.
- Preload err_cnt=0xFFFF, then an error → remains 0xFFFF; cnt_reset coincident with an error → 0.
- With FRAME_ALIGN_MONITOR_SBIT_RATE_EN: 10 LOCKED cycles with sbits_i=0x1 and 5 with 0 → sbit_rate_cnt=10. Without the macro → sbit_rate_cnt stays 0.
